// File: rtl/out_sink_pkg.sv
// Shared types and default sizes for the output-stream sink.
//   stall_mode_e : back-pressure pattern selector driven on stall_mode
//   sink_state_e : stall FSM states
//   DEF_*        : default widths/depth for out_stream_sink and its FIFO
package out_sink_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ALWAYS      = 2'd0,
    TOGGLE      = 2'd1,
    BURST_STALL = 2'd2,
    RSVD        = 2'd3
  } stall_mode_e;

  typedef enum logic {
    READY = 1'b0,
    STALL = 1'b1
  } sink_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port.
//   clk, rst           : clock, synchronous active-high reset
//   push, wr_data      : write request and word (ignored when full)
//   pop                : read request (ignored when empty)
//   rd_data, rd_valid  : popped word, valid one cycle after pop
//   count, count_next  : stored words now / after the current edge
module sync_fifo #(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int FC_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [FC_W-1:0]   count,
  output logic [FC_W-1:0]   count_next
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pop looks only at the current count, so a word written on this edge
  // becomes visible to pop on the next one.
  assign do_pop     = pop && (count != '0);
  assign do_push    = push && (count != FC_W'(DEPTH));
  assign count_next = count + FC_W'(do_push) - FC_W'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= do_pop;
      count    <= count_next;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/out_stream_sink.sv
// Drain for a 16-bit valid/ready output stream.
// Drives registered sig_out_ready under a programmable back-pressure
// pattern, buffers accepted words in a FIFO, and keeps a word count,
// checksum, saturating overflow/error tallies and a sticky protocol flag.
//   sig_clock, sig_reset         : clock, synchronous active-high reset
//   sig_out_valid/data/ready     : monitored stream (sink side)
//   sig_overflow, sig_err        : producer event pulses
//   stall_mode, stall_len        : back-pressure pattern controls
//   rd_en, rd_data, rd_valid     : FIFO pop port (1-cycle latency)
//   fifo_count, word_count, checksum, overflow_count, err_count, proto_err
module out_stream_sink
  import out_sink_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  parameter int  CNT_W  = DEF_CNT_W,
  localparam int FC_W   = $clog2(DEPTH) + 1
) (
  input  logic              sig_clock,
  input  logic              sig_reset,
  input  logic              sig_out_valid,
  input  logic [DATA_W-1:0] sig_out_data,
  output logic              sig_out_ready,
  input  logic              sig_overflow,
  input  logic              sig_err,
  input  logic [1:0]        stall_mode,
  input  logic [3:0]        stall_len,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [FC_W-1:0]   fifo_count,
  output logic [15:0]       word_count,
  output logic [15:0]       checksum,
  output logic [CNT_W-1:0]  overflow_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              proto_err
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sink_state_e       state_q, state_d;
  logic [3:0]        stall_cnt_q, stall_cnt_d;
  logic              pattern_ok_q, pattern_ok_d;
  logic [1:0]        mode_q;
  logic              accept;
  logic [FC_W-1:0]   count_next;
  logic              held_q;
  logic [DATA_W-1:0] data_q;

  assign accept = sig_out_valid && sig_out_ready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (sig_clock),
    .rst        (sig_reset),
    .push       (accept),
    .wr_data    (sig_out_data),
    .pop        (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (fifo_count),
    .count_next (count_next)
  );

  // pattern_ok_d is the back-pressure pattern for the coming cycle; the
  // ready register then also folds in FIFO space after this edge.
  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    pattern_ok_d = 1'b1;
    if (stall_mode != mode_q) begin
      state_d     = READY;
      stall_cnt_d = '0;
    end else begin
      case (stall_mode_e'(stall_mode))
        TOGGLE: pattern_ok_d = !pattern_ok_q;
        BURST_STALL: begin
          if (state_q == STALL) begin
            stall_cnt_d  = stall_cnt_q - 4'd1;
            pattern_ok_d = (stall_cnt_q == 4'd1);
            if (stall_cnt_q == 4'd1) state_d = READY;
          end else if (accept && (stall_len != 4'd0)) begin
            state_d      = STALL;
            stall_cnt_d  = stall_len;
            pattern_ok_d = 1'b0;
          end
        end
        default: pattern_ok_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      state_q        <= READY;
      stall_cnt_q    <= '0;
      pattern_ok_q   <= 1'b0;
      mode_q         <= stall_mode;
      sig_out_ready  <= 1'b0;
      word_count     <= '0;
      checksum       <= '0;
      overflow_count <= '0;
      err_count      <= '0;
      proto_err      <= 1'b0;
      held_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      pattern_ok_q  <= pattern_ok_d;
      mode_q        <= stall_mode;
      sig_out_ready <= pattern_ok_d && (count_next < FC_W'(DEPTH));
      if (accept) begin
        word_count <= word_count + 16'd1;
        checksum   <= checksum + 16'(sig_out_data);
      end
      if (sig_overflow) overflow_count <= sat_inc(overflow_count);
      if (sig_err)      err_count      <= sat_inc(err_count);
      // A stalled offer must be held with the same data until accepted.
      held_q <= sig_out_valid && !sig_out_ready;
      if ((held_q && (!sig_out_valid || (sig_out_data != data_q))) ||
          $isunknown(sig_out_valid))
        proto_err <= 1'b1;
    end
  end

  always_ff @(posedge sig_clock) begin
    data_q <= sig_out_data;
  end

endmodule

// File: tb/tb_out_stream_sink.sv
module tb_out_stream_sink;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;
  localparam int FC_W   = $clog2(DEPTH) + 1;

  logic              sig_clock = 1'b0;
  logic              sig_reset = 1'b1;
  logic              sig_out_valid = 1'b0;
  logic [DATA_W-1:0] sig_out_data = '0;
  logic              sig_out_ready;
  logic              sig_overflow = 1'b0;
  logic              sig_err = 1'b0;
  logic [1:0]        stall_mode = 2'd0;
  logic [3:0]        stall_len = 4'd0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [FC_W-1:0]   fifo_count;
  logic [15:0]       word_count;
  logic [15:0]       checksum;
  logic [CNT_W-1:0]  overflow_count;
  logic [CNT_W-1:0]  err_count;
  logic              proto_err;

  always #5 sig_clock = ~sig_clock;

  out_stream_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .sig_clock      (sig_clock),
    .sig_reset      (sig_reset),
    .sig_out_valid  (sig_out_valid),
    .sig_out_data   (sig_out_data),
    .sig_out_ready  (sig_out_ready),
    .sig_overflow   (sig_overflow),
    .sig_err        (sig_err),
    .stall_mode     (stall_mode),
    .stall_len      (stall_len),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .fifo_count     (fifo_count),
    .word_count     (word_count),
    .checksum       (checksum),
    .overflow_count (overflow_count),
    .err_count      (err_count),
    .proto_err      (proto_err)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [DATA_W-1:0] q[$];
  logic [15:0]       m_wc, m_cs;
  int                m_ovf, m_err;
  bit                m_proto, m_ready, m_rdv;
  logic [DATA_W-1:0] m_rdd;
  bit                prev_held;
  logic [DATA_W-1:0] prev_data;
  logic [1:0]        prev_mode;
  longint            cyc = 0;
  longint            anchor, stall_end;
  bit                live = 0;

  always @(posedge sig_clock) begin
    bit acc, pop, pat;
    if (sig_reset) begin
      q.delete();
      m_wc = 0; m_cs = 0; m_ovf = 0; m_err = 0;
      m_proto = 0; m_ready = 0; m_rdv = 0; m_rdd = '0;
      prev_held = 0; prev_mode = stall_mode;
      anchor = cyc + 2; stall_end = cyc;
      live = 1;
    end else if (live) begin
      acc = sig_out_valid && m_ready;
      pop = rd_en && (q.size() > 0);
      m_rdv = pop;
      if (pop) m_rdd = q.pop_front();
      if (acc) begin
        q.push_back(sig_out_data);
        m_wc = m_wc + 16'd1;
        m_cs = m_cs + sig_out_data;
      end
      if (sig_overflow && m_ovf < 255) m_ovf++;
      if (sig_err && m_err < 255) m_err++;
      if (prev_held && (!sig_out_valid || sig_out_data != prev_data)) m_proto = 1;
      prev_held = sig_out_valid && !m_ready;
      prev_data = sig_out_data;
      // pattern for the coming cycle cyc+1
      if (stall_mode != prev_mode) begin
        anchor = cyc + 1; stall_end = cyc; pat = 1;
      end else if (stall_mode == 2'd1) begin
        pat = (((cyc + 1 - anchor) % 2) == 0);
      end else if (stall_mode == 2'd2) begin
        if (acc && stall_len != 0) stall_end = cyc + stall_len;
        pat = (cyc + 1 > stall_end);
      end else begin
        pat = 1;
      end
      prev_mode = stall_mode;
      m_ready = pat && (q.size() < DEPTH);
    end
    cyc++;
  end

  always @(negedge sig_clock) begin
    if (live) begin
      chk("ready", sig_out_ready, m_ready);
      chk("fifo_count", fifo_count, q.size());
      chk("rd_valid", rd_valid, m_rdv);
      chk("rd_data", rd_data, m_rdd);
      chk("word_count", word_count, m_wc);
      chk("checksum", checksum, m_cs);
      chk("overflow_count", overflow_count, m_ovf);
      chk("err_count", err_count, m_err);
      chk("proto_err", proto_err, m_proto);
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_seq(input int first, input int n, input int max_cyc, output int used);
    int sent = 0;
    int k = 0;
    sig_out_valid = 1'b1;
    sig_out_data  = DATA_W'(first);
    while (sent < n && k < max_cyc) begin
      bit a;
      a = sig_out_ready;
      @(negedge sig_clock);
      k++;
      if (a) begin
        sent++;
        sig_out_data = DATA_W'(first + sent);
      end
    end
    sig_out_valid = 1'b0;
    used = k;
    if (sent < n) chk("push_timeout", sent, n);
  endtask

  initial begin
    int used;
    int last;
    int nacc;
    bit found;
    bit acc_next;

    // reset
    repeat (3) @(negedge sig_clock);
    chk("lit_reset_ready", sig_out_ready, 0);
    chk("lit_reset_count", fifo_count, 0);
    sig_reset = 1'b0;
    @(negedge sig_clock);
    chk("lit_ready_after_reset", sig_out_ready, 1);

    // mode 0, eight back-to-back words
    push_seq(1, 8, 20, used);
    chk("lit_b2b_cycles", used, 8);
    chk("lit_full_count", fifo_count, 8);
    chk("lit_full_checksum", checksum, 16'h0024);
    chk("lit_full_words", word_count, 8);
    chk("lit_full_ready", sig_out_ready, 0);

    // single pop on full FIFO with a held 9th word
    sig_out_valid = 1'b1; sig_out_data = 16'h0009; rd_en = 1'b1;
    @(negedge sig_clock);
    rd_en = 1'b0;
    chk("lit_pop_valid", rd_valid, 1);
    chk("lit_pop_data", rd_data, 16'h0001);
    chk("lit_pop_ready", sig_out_ready, 1);
    @(negedge sig_clock);
    sig_out_valid = 1'b0;
    chk("lit_ninth_words", word_count, 9);
    chk("lit_ninth_count", fifo_count, 8);
    chk("lit_ninth_checksum", checksum, 16'h002D);
    rd_en = 1'b1;
    repeat (10) @(negedge sig_clock);
    rd_en = 1'b0;
    chk("lit_drained", fifo_count, 0);

    // mode 2 burst stall, stall_len 3
    stall_mode = 2'd2; stall_len = 4'd3;
    repeat (2) @(negedge sig_clock);
    rd_en = 1'b1; sig_out_valid = 1'b1; sig_out_data = 16'h0100;
    last = -1; nacc = 0;
    for (int i = 0; i < 40; i++) begin
      bit a;
      a = sig_out_ready;
      @(negedge sig_clock);
      if (a) begin
        if (last >= 0) chk("lit_burst_gap", i - last, 4);
        last = i; nacc++;
        sig_out_data = sig_out_data + 16'd1;
      end
    end
    sig_out_valid = 1'b0; rd_en = 1'b0;
    chk("lit_burst_accepts", nacc, 10);

    // protocol violation: valid withdrawn while stalled (mode 1)
    stall_mode = 2'd1;
    chk("lit_proto_clear", proto_err, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge sig_clock);
      if (!sig_out_ready) found = 1;
    end
    chk("lit_toggle_low_seen", found, 1);
    sig_out_valid = 1'b1; sig_out_data = 16'hBEEF;
    @(negedge sig_clock);
    sig_out_valid = 1'b0;
    @(negedge sig_clock);
    chk("lit_proto_set", proto_err, 1);
    repeat (5) @(negedge sig_clock);
    chk("lit_proto_sticky", proto_err, 1);

    // saturating counters
    stall_mode = 2'd0;
    sig_overflow = 1'b1;
    repeat (300) @(negedge sig_clock);
    sig_overflow = 1'b0;
    chk("lit_ovf_sat", overflow_count, 255);
    chk("lit_err_untouched", err_count, 0);
    sig_err = 1'b1;
    repeat (3) @(negedge sig_clock);
    sig_err = 1'b0;
    chk("lit_err_three", err_count, 3);

    // reset with five words stored, transfer in flight
    push_seq(16'h0100, 5, 20, used);
    chk("lit_five_stored", fifo_count, 5);
    sig_reset = 1'b1; sig_out_valid = 1'b1; sig_out_data = 16'h0AAA;
    @(negedge sig_clock);
    chk("lit_rst_ready", sig_out_ready, 0);
    chk("lit_rst_count", fifo_count, 0);
    chk("lit_rst_rdv", rd_valid, 0);
    chk("lit_rst_rdd", rd_data, 0);
    chk("lit_rst_words", word_count, 0);
    chk("lit_rst_cs", checksum, 0);
    chk("lit_rst_ovf", overflow_count, 0);
    chk("lit_rst_err", err_count, 0);
    chk("lit_rst_proto", proto_err, 0);
    sig_reset = 1'b0; sig_out_valid = 1'b0;
    @(negedge sig_clock);
    chk("lit_ready_returns", sig_out_ready, 1);

    // randomized traffic against the model
    acc_next = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sig_clock);
      if (acc_next || !sig_out_valid) begin
        sig_out_valid = ($urandom_range(0, 2) != 0);
        sig_out_data  = DATA_W'($urandom);
      end else if ($urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 1) == 0) sig_out_valid = 1'b0;
        else sig_out_data = DATA_W'($urandom);
      end
      rd_en        = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 70));
      sig_overflow = ($urandom_range(0, 7) == 0);
      sig_err      = ($urandom_range(0, 7) == 0);
      stall_len    = 4'($urandom_range(0, 15));
      if (i % 250 == 0) stall_mode = 2'($urandom_range(0, 3));
      sig_reset    = (i >= 1500 && i < 1502);
      acc_next     = sig_out_valid && sig_out_ready && !sig_reset;
    end
    sig_out_valid = 1'b0; rd_en = 1'b0; sig_reset = 1'b0;
    repeat (3) @(negedge sig_clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
